// File: rtl/font_fetch_scheduler_if.sv
// Request/ROM/response bundle shared by the overlay lanes, the fetch scheduler
// and the font ROM.
interface font_fetch_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ROW_W   = 5,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [4*NUM_REQ-1:0]     req_char;
    logic [ROW_W*NUM_REQ-1:0] req_row;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     pause;
    logic                     rom_rd;
    logic [4+ROW_W-1:0]       rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic                     busy;

    // Scheduler side
    modport slave (
        input  req_valid, req_char, req_row, pause, rom_data,
        output req_ready, rom_rd, rom_addr, rsp_valid, rsp_data, busy
    );

    // Lane generators / ROM side
    modport master (
        output req_valid, req_char, req_row, pause, rom_data,
        input  req_ready, rom_rd, rom_addr, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/font_fetch_scheduler.sv
// Round-robin scheduler sharing one fixed-latency font glyph ROM between
// NUM_REQ overlay text lanes. One read issued per cycle; the lane tag rides a
// shift register matching the ROM latency so data returns to its requester.
module font_fetch_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ROW_W   = 5,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 2
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    font_fetch_scheduler_if.slave bus
);

    localparam int LANE_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ADDR_W = 4 + ROW_W;

    logic [LANE_W-1:0]  rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [LANE_W-1:0]  grant_lane;
    logic               grant_any;
    logic [LANE_W-1:0]  cand_lane;
    logic [3:0]         sel_char;
    logic [ROW_W-1:0]   sel_row;

    logic               rom_rd_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [LANE_W-1:0]  issue_lane;

    logic [ROM_LAT-1:0] sh_valid;
    logic [LANE_W-1:0]  sh_lane [ROM_LAT];

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;

    // Round-robin search starting one past the last granted lane
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        grant      = '0;
        grant_lane = '0;
        grant_any  = 1'b0;
        cand_lane  = '0;
        if (!reset && !bus.pause) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_lane = LANE_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!grant_any && bus.req_valid[cand_lane]) begin
                    grant[cand_lane] = 1'b1;
                    grant_lane       = cand_lane;
                    grant_any        = 1'b1;
                end
            end
        end
    end

    // Granted lane's character and row select the ROM word
    always_comb begin
        sel_char = bus.req_char[int'(grant_lane)*4 +: 4];
        sel_row  = bus.req_row[int'(grant_lane)*ROW_W +: ROW_W];
    end

    // Issue stage: register the ROM strobe/address and advance the pointer
    always_ff @(posedge clk_50MHz) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rr_ptr     <= LANE_W'(NUM_REQ - 1);
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            issue_lane <= '0;
        end else begin
            rom_rd_q <= grant_any;
            if (grant_any) begin
                rr_ptr     <= grant_lane;
                rom_addr_q <= {sel_char, sel_row};
                issue_lane <= grant_lane;
            end
        end
    end

    // Valid bits of the in-flight reads, cleared by reset
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            sh_valid <= '0;
        end else begin
            sh_valid[0] <= rom_rd_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                sh_valid[i] <= sh_valid[i-1];
            end
        end
    end

    // Lane tags travel alongside the valid bits
    always_ff @(posedge clk_50MHz) begin
        // NOTE: tags carry no reset; they are only used when the matching valid bit is set.
        sh_lane[0] <= issue_lane;
        for (int i = 1; i < ROM_LAT; i++) begin
            sh_lane[i] <= sh_lane[i-1];
        end
    end

    // Response stage: capture ROM data and flag the owning lane
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (sh_valid[ROM_LAT-1]) begin
                rsp_valid_q[sh_lane[ROM_LAT-1]] <= 1'b1;
                rsp_data_q                      <= bus.rom_data;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rom_rd    = rom_rd_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = rom_rd_q | (|sh_valid) | (|rsp_valid_q);

endmodule

// File: tb/tb_font_fetch_scheduler.sv
// Self-checking bench for font_fetch_scheduler: directed table, hand-written
// corner sequences and randomized traffic against a timing-arithmetic model.
module tb_font_fetch_scheduler;

    localparam int NREQ    = 2;
    localparam int ROW_W   = 5;
    localparam int DATA_W  = 16;
    localparam int ROM_LAT = 2;

    logic clk = 1'b0;
    logic reset;

    always #10 clk = ~clk;

    font_fetch_scheduler_if #(.NUM_REQ(NREQ), .ROW_W(ROW_W), .DATA_W(DATA_W)) bus ();

    font_fetch_scheduler #(
        .NUM_REQ(NREQ), .ROW_W(ROW_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk_50MHz(clk),
        .reset    (reset),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Font ROM contents: an arbitrary but fixed function of the address
    function automatic logic [15:0] rom_word(input logic [8:0] a);
        return 16'(int'(a) * 37) ^ 16'hC3A5 ^ {a[3:0], 12'h000};
    endfunction

    // Font ROM with ROM_LAT cycles of read latency; garbage when not reading
    logic [ROM_LAT-1:0] rd_pipe = '0;
    logic [8:0]         addr_pipe [ROM_LAT];
    always @(posedge clk) begin
        rd_pipe[0]   <= bus.rom_rd;
        addr_pipe[0] <= bus.rom_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            rd_pipe[i]   <= rd_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end
    assign bus.rom_data = rd_pipe[ROM_LAT-1] ? rom_word(addr_pipe[ROM_LAT-1]) : 16'h0BAD;

    // Reference model: list of accepted reads with the cycle they were accepted
    typedef struct {
        int         acc;
        int         lane;
        logic [8:0] addr;
    } ent_t;
    ent_t        q[$];
    int          cyc;
    int          m_ptr;
    logic [15:0] m_data;

    // One clock cycle: check registered outputs, drive inputs, check grant, advance
    task automatic cycle(input logic [1:0] v, input logic p, input logic r,
                         input logic [3:0] c0, input logic [4:0] r0,
                         input logic [3:0] c1, input logic [4:0] r1,
                         output logic [1:0] obs_ready, output logic [1:0] obs_rsp);
        logic       exp_rd, exp_busy;
        logic [8:0] exp_addr;
        logic [1:0] exp_rv, exp_ready;
        logic [3:0] cs [2];
        logic [4:0] rs [2];
        int         g;
        exp_rd = 1'b0; exp_busy = 1'b0; exp_addr = '0; exp_rv = '0;
        foreach (q[i]) begin
            if (q[i].acc + 1 == cyc) begin
                exp_rd   = 1'b1;
                exp_addr = q[i].addr;
            end
            if (q[i].acc + ROM_LAT + 2 == cyc) begin
                exp_rv[q[i].lane] = 1'b1;
                m_data            = rom_word(q[i].addr);
            end
            if (cyc >= q[i].acc + 1 && cyc <= q[i].acc + ROM_LAT + 2) exp_busy = 1'b1;
        end
        obs_rsp = bus.rsp_valid;
        check("rom_rd", 32'(bus.rom_rd), 32'(exp_rd));
        if (exp_rd) check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        check("rsp_data", 32'(bus.rsp_data), 32'(m_data));
        check("busy", 32'(bus.busy), 32'(exp_busy));

        bus.req_valid = v;
        bus.pause     = p;
        reset         = r;
        bus.req_char  = {c1, c0};
        bus.req_row   = {r1, r0};
        #1;
        cs[0] = c0; cs[1] = c1; rs[0] = r0; rs[1] = r1;
        g = -1;
        if (!r && !p) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = bus.req_ready;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (g >= 0) begin
            q.push_back('{acc: cyc, lane: g, addr: 9'(int'(cs[g]) * (1 << ROW_W) + int'(rs[g]))});
            m_ptr = g;
        end

        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            m_ptr  = NREQ - 1;
            m_data = '0;
        end
        while (q.size() > 0 && q[0].acc + ROM_LAT + 2 < cyc) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic [1:0] rd_o, rs_o;
        for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0, 4'h0, 5'd0, 4'h0, 5'd0, rd_o, rs_o);
    endtask

    typedef struct {
        logic [1:0] v;
        logic       p;
        logic [3:0] c0;
        logic [4:0] r0;
        logic [3:0] c1;
        logic [4:0] r1;
        logic [1:0] exp_ready;
        logic       exp_rd;
        logic [8:0] exp_addr;
    } vec_t;
    vec_t tbl [9];

    initial begin
        logic [1:0] o_rdy, o_rsp;
        int         cnt_rdy, cnt_rsp;

        // Vectors start right after reset (pointer at lane 1, lane 0 first)
        tbl[0] = '{2'b11, 1'b0, 4'hA, 5'd5,  4'h3, 5'd7,  2'b01, 1'b1, 9'h145};
        tbl[1] = '{2'b11, 1'b0, 4'hA, 5'd5,  4'hF, 5'd31, 2'b10, 1'b1, 9'h1FF};
        tbl[2] = '{2'b11, 1'b1, 4'h1, 5'd2,  4'h3, 5'd4,  2'b00, 1'b0, 9'h000};
        tbl[3] = '{2'b11, 1'b0, 4'h0, 5'd0,  4'hF, 5'd31, 2'b01, 1'b1, 9'h000};
        tbl[4] = '{2'b10, 1'b0, 4'h0, 5'd0,  4'h2, 5'd9,  2'b10, 1'b1, 9'h049};
        tbl[5] = '{2'b10, 1'b0, 4'h0, 5'd0,  4'h7, 5'd16, 2'b10, 1'b1, 9'h0F0};
        tbl[6] = '{2'b01, 1'b0, 4'h1, 5'd1,  4'h0, 5'd0,  2'b01, 1'b1, 9'h021};
        tbl[7] = '{2'b00, 1'b0, 4'h0, 5'd0,  4'h0, 5'd0,  2'b00, 1'b0, 9'h000};
        tbl[8] = '{2'b01, 1'b0, 4'h5, 5'd30, 4'h0, 5'd0,  2'b01, 1'b1, 9'h0BE};

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.pause     = 1'b0;
        bus.req_char  = '0;
        bus.req_row   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cyc    = 0;
        m_ptr  = NREQ - 1;
        m_data = '0;

        // Reset state
        check("reset req_ready", 32'(bus.req_ready), 32'h0);
        check("reset rom_rd", 32'(bus.rom_rd), 32'h0);
        check("reset rom_addr", 32'(bus.rom_addr), 32'h0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset rsp_data", 32'(bus.rsp_data), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);

        // Directed table: grant order and the issued address one cycle later
        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].p, 1'b0, tbl[i].c0, tbl[i].r0, tbl[i].c1, tbl[i].r1, o_rdy, o_rsp);
            check($sformatf("tbl%0d ready", i), 32'(o_rdy), 32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d rom_rd", i), 32'(bus.rom_rd), 32'(tbl[i].exp_rd));
            if (tbl[i].exp_rd) check($sformatf("tbl%0d rom_addr", i), 32'(bus.rom_addr), 32'(tbl[i].exp_addr));
        end
        idle(6);

        // Single request latency: accept at T, rsp_valid at T+4
        cycle(2'b01, 1'b0, 1'b0, 4'hA, 5'd5, 4'h0, 5'd0, o_rdy, o_rsp);
        check("lat rom_addr", 32'(bus.rom_addr), 32'h145);
        idle(2);
        cycle(2'b00, 1'b0, 1'b0, 4'h0, 5'd0, 4'h0, 5'd0, o_rdy, o_rsp);
        check("lat rsp T+3", 32'(o_rsp), 32'h0);
        cycle(2'b00, 1'b0, 1'b0, 4'h0, 5'd0, 4'h0, 5'd0, o_rdy, o_rsp);
        check("lat rsp T+4", 32'(o_rsp), 32'h1);
        check("lat rsp_data hold", 32'(bus.rsp_data), 32'(rom_word(9'h145)));
        idle(3);

        // Both lanes continuously: alternate grants, one response per cycle
        for (int i = 0; i < 10; i++)
            cycle(2'b11, 1'b0, 1'b0, 4'(i), 5'(i), 4'(i + 3), 5'(i * 3), o_rdy, o_rsp);
        idle(5);

        // Lane 1 alone for 8 cycles
        cnt_rdy = 0; cnt_rsp = 0;
        for (int i = 0; i < 14; i++) begin
            cycle((i < 8) ? 2'b10 : 2'b00, 1'b0, 1'b0, 4'h0, 5'd0, 4'(i), 5'(i + 7), o_rdy, o_rsp);
            if (o_rdy == 2'b10) cnt_rdy++;
            if (o_rsp == 2'b10) cnt_rsp++;
        end
        check("lane1 grants", 32'(cnt_rdy), 32'd8);
        check("lane1 responses", 32'(cnt_rsp), 32'd8);
        idle(2);

        // Pause with both requesting, then release (pointer still at lane 1)
        for (int i = 0; i < 3; i++) begin
            cycle(2'b11, 1'b1, 1'b0, 4'h4, 5'd4, 4'h5, 5'd5, o_rdy, o_rsp);
            check("pause ready", 32'(o_rdy), 32'h0);
            check("pause rom_rd", 32'(bus.rom_rd), 32'h0);
        end
        cycle(2'b11, 1'b0, 1'b0, 4'h4, 5'd4, 4'h5, 5'd5, o_rdy, o_rsp);
        check("unpause grant", 32'(o_rdy), 32'h1);
        idle(5);

        // Reset one cycle after three back-to-back accepts
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, 1'b0, 4'h6, 5'(i), 4'h9, 5'(i), o_rdy, o_rsp);
        cycle(2'b00, 1'b0, 1'b1, 4'h0, 5'd0, 4'h0, 5'd0, o_rdy, o_rsp);
        cnt_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(2'b00, 1'b0, 1'b0, 4'h0, 5'd0, 4'h0, 5'd0, o_rdy, o_rsp);
            if (o_rsp != 2'b00) cnt_rsp++;
        end
        check("post-reset responses", 32'(cnt_rsp), 32'd0);
        check("post-reset busy", 32'(bus.busy), 32'h0);
        cycle(2'b11, 1'b0, 1'b0, 4'h1, 5'd1, 4'h2, 5'd2, o_rdy, o_rsp);
        check("post-reset grant", 32'(o_rdy), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                  4'($urandom), 5'($urandom), 4'($urandom), 5'($urandom), o_rdy, o_rsp);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
